// File: rtl/draw_cmdfeed_if.sv
// Bus bundle between the command feeder, the VRAM read port and the drawer
// register interface; the feeder side is the master.
interface draw_cmdfeed_if;
  logic        mem_req;
  logic [22:0] mem_adr;
  logic        mem_ack;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        drw_req;
  logic        reg_eodl;
  logic        cif_drwsel;
  logic [3:0]  cif_regwrite;
  logic        cif_regread;
  logic [3:0]  cif_regadr;
  logic [31:0] cif_regwdata;

  modport master (
    output mem_req, mem_adr, cif_drwsel, cif_regwrite, cif_regread, cif_regadr, cif_regwdata,
    input  mem_ack, mem_rvalid, mem_rdata, drw_req, reg_eodl
  );

  modport slave (
    input  mem_req, mem_adr, cif_drwsel, cif_regwrite, cif_regread, cif_regadr, cif_regwdata,
    output mem_ack, mem_rvalid, mem_rdata, drw_req, reg_eodl
  );
endinterface

// File: rtl/draw_cmdfeed.sv
// Streams a display list from VRAM into the drawer command register, kicks the
// drawer after the first word. Define DRAW_CMDFEED_TIMEOUT_EN for a memory-stall watchdog.
module draw_cmdfeed (
  input  logic          clk,
  input  logic          rst_x,
  input  logic          start,
  input  logic          abort,
  input  logic [22:0]   dl_base,
  input  logic [15:0]   dl_words,
  output logic          busy,
  output logic          done,
  output logic          err,
  draw_cmdfeed_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_WRITE,
    S_KICK,
    S_WAITEND
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [22:0] addr;
  logic [15:0] remaining;
  logic [31:0] data;
  logic        kicked;
  logic        done_q;
  logic        err_q;
  logic        tmo_hit;
  logic        quit;
  logic        wr_data_cyc;
  logic        kick_cyc;

`ifdef DRAW_CMDFEED_TIMEOUT_EN
  logic [9:0] tmo_cnt;

  // Counts cycles stuck on the memory side; restarts whenever FETCH or WAIT is entered.
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      tmo_cnt <= '0;
    end else if ((state_nxt != state) && ((state_nxt == S_FETCH) || (state_nxt == S_WAIT))) begin
      tmo_cnt <= '0;
    end else if ((state == S_FETCH) || (state == S_WAIT)) begin
      tmo_cnt <= tmo_cnt + 10'd1;
    end
  end

  assign tmo_hit = ((state == S_FETCH) || (state == S_WAIT)) && (tmo_cnt == 10'd1023);
`else
  assign tmo_hit = 1'b0;
`endif

  assign quit        = abort || tmo_hit;
  assign wr_data_cyc = (state == S_WRITE) && bus.drw_req && !quit;
  assign kick_cyc    = (state == S_KICK) && !quit;

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // remaining is decremented on the WRITE cycle, so "nothing left" there is remaining==1.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start && (dl_words != 16'd0)) state_nxt = S_FETCH;
      S_FETCH:   if (bus.mem_ack) state_nxt = S_WAIT;
      S_WAIT:    if (bus.mem_rvalid) state_nxt = S_WRITE;
      S_WRITE: begin
        if (bus.drw_req) begin
          if (!kicked)                  state_nxt = S_KICK;
          else if (remaining != 16'd1)  state_nxt = S_FETCH;
          else                          state_nxt = S_WAITEND;
        end
      end
      S_KICK:    state_nxt = (remaining != 16'd0) ? S_FETCH : S_WAITEND;
      S_WAITEND: if (bus.reg_eodl) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
    if (quit) state_nxt = S_IDLE;
  end

  always_comb begin
    bus.mem_req      = (state == S_FETCH) && !quit;
    bus.mem_adr      = (state == S_FETCH) ? addr : '0;
    bus.cif_drwsel   = wr_data_cyc || kick_cyc;
    bus.cif_regwrite = (wr_data_cyc || kick_cyc) ? 4'hF : 4'h0;
    bus.cif_regread  = 1'b0;
    bus.cif_regadr   = kick_cyc ? 4'h1 : 4'h0;
    bus.cif_regwdata = '0;
    if (wr_data_cyc)   bus.cif_regwdata = data;
    else if (kick_cyc) bus.cif_regwdata = 32'h1;
  end

  // Datapath; an aborted transfer leaves no side effects other than the IDLE return.
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      addr      <= '0;
      remaining <= '0;
      data      <= '0;
      kicked    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if ((state == S_IDLE) && start && !abort) begin
        if (dl_words != 16'd0) begin
          addr      <= dl_base;
          remaining <= dl_words;
          kicked    <= 1'b0;
          err_q     <= 1'b0;
        end else begin
          done_q <= 1'b1;
        end
      end
      if ((state == S_WAIT) && bus.mem_rvalid && !quit) data <= bus.mem_rdata;
      if (wr_data_cyc) begin
        addr      <= addr + 23'd1;
        remaining <= remaining - 16'd1;
      end
      if (kick_cyc) kicked <= 1'b1;
      if ((state == S_WAITEND) && bus.reg_eodl && !abort) done_q <= 1'b1;
      if (tmo_hit) err_q <= 1'b1;
    end
  end

  assign busy = (state != S_IDLE);
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_draw_cmdfeed.sv
// Bench for draw_cmdfeed: a VRAM/drawer responder records every fetch and CIF write,
// and the main sequence compares them against the display-list rules.
module tb_draw_cmdfeed;

  logic        clk;
  logic        rst_x;
  logic        start;
  logic        abort;
  logic [22:0] dl_base;
  logic [15:0] dl_words;
  logic        busy;
  logic        done;
  logic        err;

  draw_cmdfeed_if bus();

  draw_cmdfeed dut (
    .clk      (clk),
    .rst_x    (rst_x),
    .start    (start),
    .abort    (abort),
    .dl_base  (dl_base),
    .dl_words (dl_words),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .bus      (bus)
  );

  int          vectors     = 0;
  int          miscompares = 0;
  int          ack_pct     = 100;
  int          rd_lat      = 0;
  bit          rand_drw    = 1'b0;
  logic        drw_level   = 1'b1;
  logic [35:0] write_q[$];
  logic [22:0] acc_q[$];
  int          done_cnt    = 0;
  int          bad_cnt     = 0;
  bit          pend_valid  = 1'b0;
  int          pend_cnt    = 0;
  logic [22:0] pend_adr    = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed no finish, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] memWord(input logic [22:0] a);
    return {~a[7:0], 1'b1, a};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // VRAM and drawer responder: drives at negedge+1, observes the settled bus at negedge+2.
  initial begin
    bus.mem_ack    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    bus.drw_req    = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = '0;
      if (!rst_x) begin
        pend_valid = 1'b0;
      end else if (pend_valid) begin
        if (pend_cnt == 0) begin
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata  = memWord(pend_adr);
          pend_valid     = 1'b0;
        end else begin
          pend_cnt--;
        end
      end
      bus.mem_ack = ($urandom_range(0, 99) < ack_pct);
      bus.drw_req = rand_drw ? 1'($urandom_range(0, 1)) : drw_level;
      #1;
      if (rst_x && bus.mem_req && bus.mem_ack) begin
        acc_q.push_back(bus.mem_adr);
        pend_valid = 1'b1;
        pend_cnt   = rd_lat;
        pend_adr   = bus.mem_adr;
      end
      if (bus.cif_drwsel) begin
        write_q.push_back({bus.cif_regadr, bus.cif_regwdata});
        if (bus.cif_regwrite != 4'hF) bad_cnt++;
        if ((bus.cif_regadr == 4'h0) && !bus.drw_req) bad_cnt++;
      end else if ((bus.cif_regwrite != 4'h0) || (bus.cif_regadr != 4'h0) || (bus.cif_regwdata != 32'h0)) begin
        bad_cnt++;
      end
      if (bus.cif_regread) bad_cnt++;
      if (done) done_cnt++;
    end
  end

  task automatic applyStimulus(input logic [22:0] base, input logic [15:0] words);
    @(negedge clk);
    dl_base  = base;
    dl_words = words;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits for the whole list, ends it with REG_EODL and compares against the expected stream.
  task automatic finishTransfer(input logic [22:0] base, input int n, input int wr0, input int acc0, input int done0);
    int guard;
    int k;
    logic [22:0] a;
    guard = 0;
    while ((write_q.size() < wr0 + n + 1) && (guard < 4000)) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("writes_issued", 64'(write_q.size() - wr0), 64'(n + 1));
    checkOutput("no_early_done", 64'(done_cnt - done0), 64'd0);
    repeat (2) @(negedge clk);
    checkOutput("busy_waitend", 64'(busy), 64'd1);
    bus.reg_eodl = 1'b1;
    @(negedge clk);
    bus.reg_eodl = 1'b0;
    checkOutput("done_pulse", 64'(done), 64'd1);
    checkOutput("idle_after_eodl", 64'(busy), 64'd0);
    @(negedge clk);
    checkOutput("done_one_cycle", 64'(done), 64'd0);
    checkOutput("done_count", 64'(done_cnt - done0), 64'd1);
    checkOutput("writes_total", 64'(write_q.size() - wr0), 64'(n + 1));
    checkOutput("fetch_count", 64'(acc_q.size() - acc0), 64'(n));
    if ((write_q.size() == wr0 + n + 1) && (acc_q.size() == acc0 + n)) begin
      k = wr0;
      for (int i = 0; i < n; i++) begin
        a = base + 23'(i);
        checkOutput("fetch_addr", 64'(acc_q[acc0 + i]), 64'(a));
        checkOutput("word_write", 64'(write_q[k]), 64'({4'h0, memWord(a)}));
        k++;
        if (i == 0) begin
          checkOutput("kick_write", 64'(write_q[k]), 64'({4'h1, 32'h1}));
          k++;
        end
      end
    end
    checkOutput("bus_protocol", 64'(bad_cnt), 64'd0);
    checkOutput("err_clear", 64'(err), 64'd0);
  endtask

  initial begin
    int wr0;
    int acc0;
    int done0;
    int guard;
    logic [22:0] rb;
    int rn;

    rst_x        = 1'b0;
    start        = 1'b0;
    abort        = 1'b0;
    dl_base      = '0;
    dl_words     = '0;
    bus.reg_eodl = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] reset state");
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_err", 64'(err), 64'd0);
    checkOutput("rst_mem_req", 64'(bus.mem_req), 64'd0);
    checkOutput("rst_mem_adr", 64'(bus.mem_adr), 64'd0);
    checkOutput("rst_drwsel", 64'(bus.cif_drwsel), 64'd0);
    checkOutput("rst_regwrite", 64'(bus.cif_regwrite), 64'd0);
    checkOutput("rst_regread", 64'(bus.cif_regread), 64'd0);
    checkOutput("rst_regadr", 64'(bus.cif_regadr), 64'd0);
    checkOutput("rst_regwdata", 64'(bus.cif_regwdata), 64'd0);
    rst_x = 1'b1;
    @(negedge clk);

    $display("[TB] three-word list at 0x100");
    wr0 = write_q.size(); acc0 = acc_q.size(); done0 = done_cnt;
    applyStimulus(23'h100, 16'd3);
    finishTransfer(23'h100, 3, wr0, acc0, done0);

    $display("[TB] empty list");
    wr0 = write_q.size(); acc0 = acc_q.size(); done0 = done_cnt;
    applyStimulus(23'h1234, 16'd0);
    checkOutput("empty_done", 64'(done), 64'd1);
    checkOutput("empty_busy", 64'(busy), 64'd0);
    @(negedge clk);
    checkOutput("empty_done_once", 64'(done), 64'd0);
    repeat (3) @(negedge clk);
    checkOutput("empty_no_fetch", 64'(acc_q.size() - acc0), 64'd0);
    checkOutput("empty_no_write", 64'(write_q.size() - wr0), 64'd0);

    $display("[TB] drawer stall, start ignored while busy");
    drw_level = 1'b0;
    wr0 = write_q.size(); acc0 = acc_q.size(); done0 = done_cnt;
    applyStimulus(23'h2345, 16'd1);
    repeat (4) @(negedge clk);
    start = 1'b1; dl_base = 23'h0; dl_words = 16'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    checkOutput("stall_no_write", 64'(write_q.size() - wr0), 64'd0);
    checkOutput("stall_busy", 64'(busy), 64'd1);
    drw_level = 1'b1;
    finishTransfer(23'h2345, 1, wr0, acc0, done0);

    $display("[TB] address wrap");
    wr0 = write_q.size(); acc0 = acc_q.size(); done0 = done_cnt;
    applyStimulus(23'h7FFFFF, 16'd2);
    finishTransfer(23'h7FFFFF, 2, wr0, acc0, done0);

    $display("[TB] abort in WAIT with late read data");
    rd_lat = 8;
    wr0 = write_q.size(); acc0 = acc_q.size(); done0 = done_cnt;
    applyStimulus(23'h555, 16'd2);
    guard = 0;
    while ((acc_q.size() == acc0) && (guard < 100)) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("abort_fetch_seen", 64'(acc_q.size() - acc0), 64'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abort_idle", 64'(busy), 64'd0);
    checkOutput("abort_req_drop", 64'(bus.mem_req), 64'd0);
    repeat (15) @(negedge clk);
    checkOutput("abort_no_write", 64'(write_q.size() - wr0), 64'd0);
    checkOutput("abort_no_done", 64'(done_cnt - done0), 64'd0);
    checkOutput("abort_stay_idle", 64'(busy), 64'd0);
    rd_lat = 0;

    $display("[TB] abort beats start");
    acc0 = acc_q.size();
    @(negedge clk);
    start = 1'b1; abort = 1'b1; dl_base = 23'h10; dl_words = 16'd3;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    checkOutput("abort_prio_busy", 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
    checkOutput("abort_prio_fetch", 64'(acc_q.size() - acc0), 64'd0);

    $display("[TB] reset mid-transfer");
    wr0 = write_q.size();
    applyStimulus(23'h40, 16'd4);
    guard = 0;
    while ((write_q.size() == wr0) && (guard < 100)) begin
      @(negedge clk);
      guard++;
    end
    rst_x = 1'b0;
    #2;
    checkOutput("midrst_busy", 64'(busy), 64'd0);
    checkOutput("midrst_mem_req", 64'(bus.mem_req), 64'd0);
    checkOutput("midrst_drwsel", 64'(bus.cif_drwsel), 64'd0);
    checkOutput("midrst_wdata", 64'(bus.cif_regwdata), 64'd0);
    @(negedge clk);
    rst_x = 1'b1;
    @(negedge clk);

`ifdef DRAW_CMDFEED_TIMEOUT_EN
    $display("[TB] memory never acknowledges, watchdog");
    ack_pct = 0;
    done0 = done_cnt;
    applyStimulus(23'h77, 16'd2);
    guard = 0;
    while (busy && (guard < 1200)) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("tmo_err", 64'(err), 64'd1);
    checkOutput("tmo_idle", 64'(busy), 64'd0);
    checkOutput("tmo_no_done", 64'(done_cnt - done0), 64'd0);
    checkOutput("tmo_cycles", 64'((guard >= 1015) && (guard <= 1035)), 64'd1);
    ack_pct = 100;
`else
    $display("[TB] memory stall without watchdog");
    ack_pct = 0;
    wr0 = write_q.size(); acc0 = acc_q.size(); done0 = done_cnt;
    applyStimulus(23'h77, 16'd2);
    repeat (1100) @(negedge clk);
    checkOutput("stall_still_busy", 64'(busy), 64'd1);
    checkOutput("stall_err_low", 64'(err), 64'd0);
    ack_pct = 100;
    finishTransfer(23'h77, 2, wr0, acc0, done0);
`endif

    $display("[TB] randomized lists");
    rand_drw = 1'b1;
    for (int t = 0; t < 6; t++) begin
      rb      = 23'($urandom);
      rn      = $urandom_range(1, 6);
      ack_pct = $urandom_range(30, 100);
      rd_lat  = $urandom_range(0, 3);
      wr0 = write_q.size(); acc0 = acc_q.size(); done0 = done_cnt;
      applyStimulus(rb, 16'(rn));
      finishTransfer(rb, rn, wr0, acc0, done0);
    end
    rand_drw = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
